out_acc_buf: RTL and testbench



---
 rtl/out_acc_buf.sv | 126 ++++++++++++
 tb/tb_out_acc_buf.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_acc_buf.sv
// out_acc_buf: double-banked output accumulation buffer.
// One result element per cycle enters a 3-stage read-modify-write pipeline
// into the bank named by outp. The opposite bank is drained by the
// destination streamer through an independent registered read port.
module out_acc_buf #(
  parameter int DW  = 16,
  parameter int AW  = 12,
  parameter int SAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          outr,
  input  logic          accr,
  input  logic [AW-1:0] oa,
  input  logic [DW-1:0] din,
  input  logic          outp,
  input  logic          dst_v,
  input  logic [AW-1:0] dst_a,
  input  logic          dst_bank,
  output logic [DW-1:0] dst_d,
  output logic          dst_dv,
  output logic          busy
);

  localparam int DEPTH = 1 << AW;
  localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

  typedef struct packed {
    logic          bank;
    logic [AW-1:0] addr;
    logic          acc;
    logic [DW-1:0] data;
  } op_t;

  // Two banks of storage; contents survive reset.
  logic [DW-1:0] mem_q [2][DEPTH];

  // Stage valid bits: [1] = S1, [2] = S2, [3] = S3 (forwarding only).
  logic [3:1]    vld_q;
  op_t           s1_q, s2_q;
  logic [DW-1:0] rd_q;
  logic [DW-1:0] addend_d, addend_q;
  logic [DW-1:0] sum_d;
  logic [DW:0]   wide;

  // S3 remembers the last write for the op that read on the same edge.
  logic          s3_bank_q;
  logic [AW-1:0] s3_addr_q;
  logic [DW-1:0] s3_val_q;

  logic          busy_q;
  logic [DW-1:0] dst_d_q;
  logic          dst_dv_q;

  logic          s2_hit, s3_hit, wr_en;

  // Stage valid shift register; reset drops every op in flight.
  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= {vld_q[2:1], outr};
  end

  // Datapath stage registers (no reset needed, qualified by vld_q).
  always_ff @(posedge clk) begin
    s1_q.bank <= outp;
    s1_q.addr <= oa;
    s1_q.acc  <= accr;
    s1_q.data <= din;
    if (outr && accr) rd_q <= mem_q[outp][oa];
    s2_q      <= s1_q;
    addend_q  <= addend_d;
    s3_bank_q <= s2_q.bank;
    s3_addr_q <= s2_q.addr;
    s3_val_q  <= sum_d;
  end

  // S1 hazard forwarding: newest in-flight value for the same bank/address wins.
  always_comb begin
    s2_hit   = vld_q[2] && (s2_q.bank == s1_q.bank) && (s2_q.addr == s1_q.addr);
    s3_hit   = vld_q[3] && (s3_bank_q == s1_q.bank) && (s3_addr_q == s1_q.addr);
    addend_d = rd_q;
    if (s2_hit)      addend_d = sum_d;
    else if (s3_hit) addend_d = s3_val_q;
  end

  // S2 add: full-precision sum, then clamp or wrap back to DW bits.
  always_comb begin
    wide  = {addend_q[DW-1], addend_q} + {s2_q.data[DW-1], s2_q.data};
    sum_d = s2_q.data;
    if (s2_q.acc) begin
      if ((SAT != 0) && (wide[DW] != wide[DW-1])) sum_d = wide[DW] ? SMIN : SMAX;
      else                                         sum_d = wide[DW-1:0];
    end
  end

  // A reset edge also suppresses the write of the op sitting in S2.
  assign wr_en = vld_q[2] && !rst;

  // Memory write port (read-first: same-edge readers see the old word).
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[s2_q.bank][s2_q.addr] <= sum_d;
  end

  // busy covers cycles t+1..t+2 of every accepted op.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= 1'b0;
    else     busy_q <= outr | vld_q[1];
  end

  // Destination streamer read port; data holds when no request.
  always_ff @(posedge clk) begin
    if (rst) begin
      dst_dv_q <= 1'b0;
      dst_d_q  <= '0;
    end else begin
      dst_dv_q <= dst_v;
      if (dst_v) dst_d_q <= mem_q[dst_bank][dst_a];
    end
  end

  assign dst_d  = dst_d_q;
  assign dst_dv = dst_dv_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_out_acc_buf.sv
// Self-checking bench for out_acc_buf: a saturating and a wrapping instance
// share stimulus; a sequential array model gives the expected memory image.
module tb_out_acc_buf;
  localparam int DW   = 16;
  localparam int AW   = 12;
  localparam int NA   = 1 << AW;
  localparam int MAXV = (1 << (DW-1)) - 1;
  localparam int MINV = -(1 << (DW-1));

  logic          clk = 1'b0;
  logic          rst, outr, accr, outp, dst_v, dst_bank;
  logic [AW-1:0] oa, dst_a;
  logic [DW-1:0] din;
  logic [DW-1:0] dst_d_s, dst_d_w;
  logic          dst_dv_s, dst_dv_w, busy_s, busy_w;

  int total = 0;
  int bad   = 0;

  // Reference memory images: saturating and wrapping.
  int m_s [2][NA];
  int m_w [2][NA];

  always #5 clk = ~clk;

  out_acc_buf #(.DW(DW), .AW(AW), .SAT(1)) dut_s (
    .clk(clk), .rst(rst), .outr(outr), .accr(accr), .oa(oa), .din(din),
    .outp(outp), .dst_v(dst_v), .dst_a(dst_a), .dst_bank(dst_bank),
    .dst_d(dst_d_s), .dst_dv(dst_dv_s), .busy(busy_s));

  out_acc_buf #(.DW(DW), .AW(AW), .SAT(0)) dut_w (
    .clk(clk), .rst(rst), .outr(outr), .accr(accr), .oa(oa), .din(din),
    .outp(outp), .dst_v(dst_v), .dst_a(dst_a), .dst_bank(dst_bank),
    .dst_d(dst_d_w), .dst_dv(dst_dv_w), .busy(busy_w));

  logic [2*DW+1:0] rd_obs;
  logic [1:0]      busy_obs;
  assign rd_obs   = {dst_dv_s, dst_d_s, dst_dv_w, dst_d_w};
  assign busy_obs = {busy_s, busy_w};

  function automatic int add_s(input int a, input int b);
    int s;
    s = a + b;
    if (s > MAXV) s = MAXV;
    if (s < MINV) s = MINV;
    return s;
  endfunction

  function automatic int add_w(input int a, input int b);
    int s;
    s = (a + b) & ((1 << DW) - 1);
    if (s > MAXV) s = s - (1 << DW);
    return s;
  endfunction

  // Ops retire in issue order, so the model applies them immediately.
  function automatic void model_op(input bit a, input bit b, input int addr, input int data);
    if (a) begin
      m_s[b][addr] = add_s(m_s[b][addr], data);
      m_w[b][addr] = add_w(m_w[b][addr], data);
    end else begin
      m_s[b][addr] = data;
      m_w[b][addr] = data;
    end
  endfunction

  function automatic logic [2*DW+1:0] rd_exp(input bit b, input int addr);
    int es, ew;
    logic [DW-1:0] vs, vw;
    es = m_s[b][addr];
    ew = m_w[b][addr];
    vs = es[DW-1:0];
    vw = ew[DW-1:0];
    return {1'b1, vs, 1'b1, vw};
  endfunction

  // One clock cycle with the given inputs; returns 1 time unit after the edge.
  task automatic drive(input bit o, input bit a, input bit b, input int addr, input int data,
                       input bit rv, input bit rb, input int ra, input bit r);
    outr = o; accr = a; outp = b; oa = addr[AW-1:0]; din = data[DW-1:0];
    dst_v = rv; dst_bank = rb; dst_a = ra[AW-1:0]; rst = r;
    @(posedge clk); #1;
  endtask

  task automatic issue(input bit a, input bit b, input int addr, input int data);
    model_op(a, b, addr, data);
    drive(1'b1, a, b, addr, data, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic rd_req(input bit b, input int addr);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, b, addr, 1'b0);
  endtask

  task automatic test_reset;
    drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b1);
    total++;
    if ({dst_dv_s, dst_dv_w, busy_s, busy_w} !== 4'b0000) begin
      bad++; $display("FAIL rst_ctl: got %b want 0000", {dst_dv_s, dst_dv_w, busy_s, busy_w});
    end
    total++;
    if ({dst_d_s, dst_d_w} !== '0) begin
      bad++; $display("FAIL rst_data: got %h want 0", {dst_d_s, dst_d_w});
    end
    idle(1);
  endtask

  task automatic test_overwrite;
    issue(1'b0, 1'b0, 5, 100);
    total++;
    if (busy_obs !== 2'b11) begin bad++; $display("FAIL ovw_busy1: got %b want 11", busy_obs); end
    idle(1);
    total++;
    if (busy_obs !== 2'b11) begin bad++; $display("FAIL ovw_busy2: got %b want 11", busy_obs); end
    idle(1);
    total++;
    if (busy_obs !== 2'b00) begin bad++; $display("FAIL ovw_busy3: got %b want 00", busy_obs); end
    idle(1);
    rd_req(1'b0, 5);
    total++;
    if (rd_obs !== rd_exp(1'b0, 5)) begin
      bad++; $display("FAIL ovw_rd: got %h want %h", rd_obs, rd_exp(1'b0, 5));
    end
    idle(1);
    total++;
    if ({dst_dv_s, dst_dv_w} !== 2'b00) begin
      bad++; $display("FAIL ovw_dv_drop: got %b want 00", {dst_dv_s, dst_dv_w});
    end
  endtask

  task automatic test_accumulate;
    issue(1'b0, 1'b0, 7, 10);
    idle(3);
    issue(1'b1, 1'b0, 7, 3);
    idle(3);
    rd_req(1'b0, 7);
    total++;
    if (rd_obs !== rd_exp(1'b0, 7)) begin
      bad++; $display("FAIL acc_13: got %h want %h", rd_obs, rd_exp(1'b0, 7));
    end
    issue(1'b1, 1'b0, 7, -20);
    idle(3);
    rd_req(1'b0, 7);
    total++;
    if (rd_obs !== rd_exp(1'b0, 7)) begin
      bad++; $display("FAIL acc_m7: got %h want %h", rd_obs, rd_exp(1'b0, 7));
    end
  endtask

  task automatic test_back_to_back;
    issue(1'b0, 1'b1, 2, 0);
    idle(3);
    for (int i = 1; i <= 4; i++) issue(1'b1, 1'b1, 2, i);
    idle(3);
    rd_req(1'b1, 2);
    total++;
    if (rd_obs !== rd_exp(1'b1, 2)) begin
      bad++; $display("FAIL b2b_sum: got %h want %h", rd_obs, rd_exp(1'b1, 2));
    end
  endtask

  // Same address two cycles apart, unrelated op in between.
  task automatic test_gap1;
    int pre [3] = '{1, 32760, -32760};
    int d1  [3] = '{5, 100, -100};
    int d2  [3] = '{6, 0, 0};
    for (int k = 0; k < 3; k++) begin
      issue(1'b0, 1'b0, 9, pre[k]);
      issue(1'b0, 1'b0, 10, k);
      idle(3);
      issue(1'b1, 1'b0, 9, d1[k]);
      issue(1'b1, 1'b0, 10, 1);
      issue(1'b1, 1'b0, 9, d2[k]);
      idle(3);
      rd_req(1'b0, 9);
      total++;
      if (rd_obs !== rd_exp(1'b0, 9)) begin
        bad++; $display("FAIL gap1_%0d: got %h want %h", k, rd_obs, rd_exp(1'b0, 9));
      end
      rd_req(1'b0, 10);
      total++;
      if (rd_obs !== rd_exp(1'b0, 10)) begin
        bad++; $display("FAIL gap1_other_%0d: got %h want %h", k, rd_obs, rd_exp(1'b0, 10));
      end
    end
  endtask

  task automatic test_reset_mid;
    issue(1'b0, 1'b0, 4, 1);
    issue(1'b0, 1'b0, 6, 2);
    idle(3);
    // Op in S1 at the reset edge: never written (model untouched).
    drive(1'b1, 1'b0, 1'b0, 4, 55, 1'b0, 1'b0, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 4, 1'b1);
    total++;
    if ({busy_s, busy_w, dst_dv_s, dst_dv_w} !== 4'b0000) begin
      bad++; $display("FAIL rstmid_ctl: got %b want 0000", {busy_s, busy_w, dst_dv_s, dst_dv_w});
    end
    idle(3);
    rd_req(1'b0, 4);
    total++;
    if (rd_obs !== rd_exp(1'b0, 4)) begin
      bad++; $display("FAIL rstmid_s1: got %h want %h", rd_obs, rd_exp(1'b0, 4));
    end
    // Op in S2 at the reset edge: write suppressed.
    drive(1'b1, 1'b0, 1'b0, 6, 77, 1'b0, 1'b0, 0, 1'b0);
    idle(1);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1);
    idle(3);
    rd_req(1'b0, 6);
    total++;
    if (rd_obs !== rd_exp(1'b0, 6)) begin
      bad++; $display("FAIL rstmid_s2: got %h want %h", rd_obs, rd_exp(1'b0, 6));
    end
  endtask

  task automatic test_ping_pong;
    logic [DW-1:0] r;
    for (int i = 0; i < 8; i++) begin
      r = DW'($urandom);
      issue(1'b0, 1'b1, 100 + i, int'($signed(r)));
      r = DW'($urandom);
      issue(1'b0, 1'b0, 100 + i, int'($signed(r)));
    end
    idle(3);
    // Write bank 0, stream bank 1.
    for (int i = 0; i < 8; i++) begin
      r = DW'($urandom);
      model_op(1'b1, 1'b0, 100 + i, int'($signed(r)));
      drive(1'b1, 1'b1, 1'b0, 100 + i, int'($signed(r)), 1'b1, 1'b1, 100 + i, 1'b0);
      total++;
      if (rd_obs !== rd_exp(1'b1, 100 + i)) begin
        bad++; $display("FAIL pp_b1_%0d: got %h want %h", i, rd_obs, rd_exp(1'b1, 100 + i));
      end
    end
    idle(3);
    // Swap: write bank 1, stream bank 0.
    for (int i = 0; i < 8; i++) begin
      r = DW'($urandom);
      model_op(1'b1, 1'b1, 100 + i, int'($signed(r)));
      drive(1'b1, 1'b1, 1'b1, 100 + i, int'($signed(r)), 1'b1, 1'b0, 100 + i, 1'b0);
      total++;
      if (rd_obs !== rd_exp(1'b0, 100 + i)) begin
        bad++; $display("FAIL pp_b0_%0d: got %h want %h", i, rd_obs, rd_exp(1'b0, 100 + i));
      end
    end
    idle(1);
    total++;
    if (busy_obs !== 2'b11) begin bad++; $display("FAIL pp_busy2: got %b want 11", busy_obs); end
    idle(1);
    total++;
    if (busy_obs !== 2'b00) begin bad++; $display("FAIL pp_busy3: got %b want 00", busy_obs); end
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 8; i++) begin
        rd_req(b[0], 100 + i);
        total++;
        if (rd_obs !== rd_exp(b[0], 100 + i)) begin
          bad++; $display("FAIL pp_final_b%0d_%0d: got %h want %h", b, i, rd_obs, rd_exp(b[0], 100 + i));
        end
      end
    end
  endtask

  // Dense random traffic on a small window: heavy forwarding and bank flips.
  task automatic test_random;
    logic [DW-1:0] r;
    bit a, b;
    int addr;
    for (int k = 0; k < 32; k++) begin
      r = DW'($urandom);
      issue(1'b0, k[4], k % 16, int'($signed(r)));
    end
    for (int k = 0; k < 300; k++) begin
      r    = DW'($urandom);
      a    = ($urandom_range(0, 3) != 0);
      b    = $urandom_range(0, 1) != 0;
      addr = $urandom_range(0, 7);
      if ($urandom_range(0, 4) == 0) idle(1);
      issue(a, b, addr, int'($signed(r)));
    end
    idle(3);
    for (int bk = 0; bk < 2; bk++) begin
      for (int i = 0; i < 16; i++) begin
        rd_req(bk[0], i);
        total++;
        if (rd_obs !== rd_exp(bk[0], i)) begin
          bad++; $display("FAIL rand_b%0d_%0d: got %h want %h", bk, i, rd_obs, rd_exp(bk[0], i));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; outr = 1'b0; accr = 1'b0; outp = 1'b0; oa = '0; din = '0;
    dst_v = 1'b0; dst_bank = 1'b0; dst_a = '0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NA; i++) begin
        m_s[b][i] = 0;
        m_w[b][i] = 0;
      end
    test_reset;
    test_overwrite;
    test_accumulate;
    test_back_to_back;
    test_gap1;
    test_reset_mid;
    test_ping_pong;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
